// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR read/write arbiter.
package ddr_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_DATA
   } state_e;

   localparam logic SRC_WR = 1'b0;
   localparam logic SRC_RD = 1'b1;

   function automatic int data_w(input int dq_w);
      return 8 * dq_w;
   endfunction

endpackage

// File: rtl/ddr_rw_arbiter_if.sv
// Client-side and controller-side bus of the arbiter; master = arbiter view.
interface ddr_rw_arbiter_if #(
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int MEM_DQ_WIDTH    = 32
);
   localparam int DW = ddr_arb_pkg::data_w(MEM_DQ_WIDTH);

   logic                       wr_req, wr_gnt, wr_data_req, wr_done;
   logic [CTRL_ADDR_WIDTH-1:0] wr_addr;
   logic [3:0]                 wr_len;
   logic [DW-1:0]              wr_data;
   logic                       rd_req, rd_gnt, rd_data_vld, rd_done;
   logic [CTRL_ADDR_WIDTH-1:0] rd_addr;
   logic [3:0]                 rd_len;
   logic [DW-1:0]              rd_data;
   logic                       proto_err;
   logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr, axi_araddr;
   logic [3:0]                 axi_awlen, axi_arlen;
   logic                       axi_awvalid, axi_awready, axi_arvalid, axi_arready;
   logic [DW-1:0]              axi_wdata, axi_rdata;
   logic                       axi_wready, axi_wusero_last, axi_rlast, axi_rvalid;

   modport master (
      input  wr_req, wr_addr, wr_len, wr_data, rd_req, rd_addr, rd_len,
             axi_awready, axi_wready, axi_wusero_last, axi_arready,
             axi_rdata, axi_rlast, axi_rvalid,
      output wr_gnt, wr_data_req, wr_done, rd_gnt, rd_data, rd_data_vld,
             rd_done, proto_err, axi_awaddr, axi_awlen, axi_awvalid,
             axi_wdata, axi_araddr, axi_arlen, axi_arvalid
   );

   modport slave (
      output wr_req, wr_addr, wr_len, wr_data, rd_req, rd_addr, rd_len,
             axi_awready, axi_wready, axi_wusero_last, axi_arready,
             axi_rdata, axi_rlast, axi_rvalid,
      input  wr_gnt, wr_data_req, wr_done, rd_gnt, rd_data, rd_data_vld,
             rd_done, proto_err, axi_awaddr, axi_awlen, axi_awvalid,
             axi_wdata, axi_araddr, axi_arlen, axi_arvalid
   );
endinterface

// File: rtl/ddr_arb_rr.sv
// Two-requester round-robin picker; on a tie the side not served last wins.
import ddr_arb_pkg::*;

module ddr_arb_rr (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic req_wr_i,
   input  logic req_rd_i,
   output logic gnt_wr_o,
   output logic gnt_rd_o
);
   logic last_q, last_d;

   always_comb begin
      gnt_wr_o = en_i && req_wr_i && !(req_rd_i && (last_q == SRC_WR));
      gnt_rd_o = en_i && req_rd_i && !gnt_wr_o;
      last_d   = last_q;
      if (gnt_wr_o)      last_d = SRC_WR;
      else if (gnt_rd_o) last_d = SRC_RD;
   end

   // Resetting to READ makes the first tie go to the writer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= SRC_RD;
      else        last_q <= last_d;
   end
endmodule

// File: rtl/ddr_rw_arbiter.sv
// Shares the DDR controller AXI port between one write and one read client,
// one burst in flight, with an independent beat count checked against last flags.
import ddr_arb_pkg::*;

module ddr_rw_arbiter #(
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int MEM_DQ_WIDTH    = 32
) (
   input logic              core_clk,
   input logic              core_clk_rst_n,
   input logic              ddr_init_done,
   ddr_rw_arbiter_if.master bus
);
   localparam int DW = data_w(MEM_DQ_WIDTH);

   state_e                     state_q;
   logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
   logic [3:0]                 awlen_q, arlen_q, beat_cnt_q;
   logic                       awvalid_q, arvalid_q, wr_gnt_q, rd_gnt_q;
   logic                       wr_done_q, rd_done_q, rd_vld_q, proto_err_q;
   logic [DW-1:0]              rd_data_q;
   logic                       pick_wr, pick_rd, grant_en;

   assign grant_en = (state_q == IDLE) && ddr_init_done;

   ddr_arb_rr u_rr (
      .clk      (core_clk),
      .rst_n    (core_clk_rst_n),
      .en_i     (grant_en),
      .req_wr_i (bus.wr_req),
      .req_rd_i (bus.rd_req),
      .gnt_wr_o (pick_wr),
      .gnt_rd_o (pick_rd)
   );

   always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
      if (!core_clk_rst_n) begin
         state_q     <= IDLE;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         awlen_q     <= '0;
         arlen_q     <= '0;
         beat_cnt_q  <= '0;
         awvalid_q   <= 1'b0;
         arvalid_q   <= 1'b0;
         wr_gnt_q    <= 1'b0;
         rd_gnt_q    <= 1'b0;
         wr_done_q   <= 1'b0;
         rd_done_q   <= 1'b0;
         rd_vld_q    <= 1'b0;
         proto_err_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         wr_gnt_q  <= 1'b0;
         rd_gnt_q  <= 1'b0;
         wr_done_q <= 1'b0;
         rd_done_q <= 1'b0;
         rd_vld_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_wr) begin
                  wr_gnt_q  <= 1'b1;
                  awvalid_q <= 1'b1;
                  awaddr_q  <= bus.wr_addr;
                  awlen_q   <= bus.wr_len;
                  state_q   <= WR_ADDR;
               end else if (pick_rd) begin
                  rd_gnt_q  <= 1'b1;
                  arvalid_q <= 1'b1;
                  araddr_q  <= bus.rd_addr;
                  arlen_q   <= bus.rd_len;
                  state_q   <= RD_ADDR;
               end
            end
            WR_ADDR: begin
               if (bus.axi_awready) begin
                  awvalid_q  <= 1'b0;
                  beat_cnt_q <= awlen_q;
                  state_q    <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (bus.axi_wready) begin
                  if (bus.axi_wusero_last && (beat_cnt_q != 4'd0)) proto_err_q <= 1'b1;
                  if (beat_cnt_q == 4'd0) begin
                     wr_done_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     beat_cnt_q <= beat_cnt_q - 4'd1;
                  end
               end
            end
            RD_ADDR: begin
               if (bus.axi_arready) begin
                  arvalid_q  <= 1'b0;
                  beat_cnt_q <= arlen_q;
                  state_q    <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (bus.axi_rvalid) begin
                  rd_data_q <= bus.axi_rdata;
                  rd_vld_q  <= 1'b1;
                  // The controller's rlast is only cross-checked; our own count ends the burst.
                  if (bus.axi_rlast != (beat_cnt_q == 4'd0)) proto_err_q <= 1'b1;
                  if (beat_cnt_q == 4'd0) begin
                     rd_done_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     beat_cnt_q <= beat_cnt_q - 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.wr_gnt      = wr_gnt_q;
   assign bus.rd_gnt      = rd_gnt_q;
   assign bus.wr_done     = wr_done_q;
   assign bus.rd_done     = rd_done_q;
   assign bus.rd_data_vld = rd_vld_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.proto_err   = proto_err_q;
   assign bus.axi_awaddr  = awaddr_q;
   assign bus.axi_awlen   = awlen_q;
   assign bus.axi_awvalid = awvalid_q;
   assign bus.axi_araddr  = araddr_q;
   assign bus.axi_arlen   = arlen_q;
   assign bus.axi_arvalid = arvalid_q;
   assign bus.axi_wdata   = bus.wr_data;
   assign bus.wr_data_req = (state_q == WR_DATA) && bus.axi_wready;
endmodule
